// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side consumer for an async FIFO. Hides the FIFO's
//               one-cycle read latency behind a small FWFT output buffer and
//               presents the data as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_seen,
    output logic                  busy
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(OUT_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(OUT_DEPTH);

    logic [DATA_WIDTH-1:0] ram [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic [OCC_W:0]        credit_used;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit counts the in-flight word but not a same-cycle pop, so m_ready
    // never reaches rd_en combinationally.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign rd_en       = ~rst & enable & ~empty & (credit_used < DEPTH_EXT);

    assign m_valid = (occ != '0);
    assign m_data  = ram[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign busy    = inflight | m_valid;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight       <= 1'b0;
            occ            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rd_count       <= '0;
            underflow_seen <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                ram[wr_ptr] <= rdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                rd_count <= rd_count + 1'b1;
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (underflow) begin
                underflow_seen <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_drain
// Description : Scoreboard bench for fifo_rd_drain with a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          rd_clk = 1'b0;
    logic          rst, enable, empty, underflow, m_ready;
    logic          rd_en, m_valid, underflow_seen, busy;
    logic [DW-1:0] rdata, m_data;
    logic [CW-1:0] rd_count;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_drain #(.DATA_WIDTH(DW), .OUT_DEPTH(3), .CNT_WIDTH(CW)) dut (
        .rd_clk(rd_clk), .rst(rst), .enable(enable), .empty(empty),
        .underflow(underflow), .rdata(rdata), .rd_en(rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .rd_count(rd_count), .underflow_seen(underflow_seen), .busy(busy)
    );

    logic [DW-1:0] fq[$];      // contents of the upstream FIFO
    logic [DW-1:0] exp_q[$];   // words the stream must deliver, in order
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, t_rd = -1, t_v = -1, t_lv = -1, n_rd = 0;
    int delivered = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    function automatic void check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    // One clock: observe at the falling edge, then model the FIFO read port
    // (rdata valid the cycle after a sampled rd_en) just after the rising edge.
    task automatic tick();
        bit fire;
        @(negedge rd_clk);
        fire = rd_en;
        if (empty) check("rd_en_while_empty", int'(rd_en), 0);
        if (rd_en && t_rd < 0) t_rd = cyc;
        if (m_valid) begin
            if (t_v < 0) t_v = cyc;
            t_lv = cyc;
        end
        if (fire) n_rd++;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (fire) rdata = (fq.size() == 0) ? 8'hEE : fq.pop_front();
        empty = (fq.size() == 0);
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            done = !busy && (fq.size() == 0 || !enable);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%0d fifo_left=%0d expected idle", name, busy, fq.size());
        end
    endtask

    // Scoreboard monitor: pops the expected queue on every delivered word.
    always @(negedge rd_clk) begin
        if (rst) begin
            delivered = 0;
            hold_v    = 1'b0;
        end else begin
            check("rd_count_track", int'(rd_count), delivered % (1 << CW));
            if (hold_v) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(hold_d));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", int'(m_data), 256);
                else check("m_data", int'(m_data), int'(exp_q.pop_front()));
                delivered++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        bit done;
        rst = 1'b1; enable = 1'b0; empty = 1'b1; underflow = 1'b0;
        m_ready = 1'b0; rdata = '0;
        #1;
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_data", int'(m_data), 0);
        check("reset_rd_count", int'(rd_count), 0);
        check("reset_uflow", int'(underflow_seen), 0);
        check("reset_busy", int'(busy), 0);
        repeat (3) tick();
        rst = 1'b0;

        // Streaming burst with latency and throughput checks
        t_rd = -1; t_v = -1; t_lv = -1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h11 + i));
        enable = 1'b1; m_ready = 1'b1;
        wait_idle(60, "stream");
        check("stream_latency", t_v - t_rd, 2);
        check("stream_rate", t_lv - t_v, 7);
        check("stream_count", int'(rd_count), 8);
        check("stream_rd_en_idle", int'(rd_en), 0);

        // Backpressure: only the buffer's worth of reads may be issued
        m_ready = 1'b0; n_rd = 0;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h11 + i));
        repeat (10) tick();
        check("bp_rd_en_pulses", n_rd, 3);
        check("bp_valid", int'(m_valid), 1);
        check("bp_head", int'(m_data), 8'h11);
        m_ready = 1'b1;
        wait_idle(80, "bp");
        check("bp_no_loss", exp_q.size(), 0);
        check("bp_count", int'(rd_count), 0);

        // Empty FIFO and sticky underflow
        n_rd = 0;
        repeat (20) tick();
        check("empty_no_rd_en", n_rd, 0);
        check("empty_no_uflow", int'(underflow_seen), 0);
        underflow = 1'b1;
        tick();
        underflow = 1'b0;
        check("uflow_set", int'(underflow_seen), 1);
        repeat (5) tick();
        check("uflow_sticky", int'(underflow_seen), 1);

        // Enable dropped right after the first read
        enable = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_word(DW'(8'h31 + i));
        n_rd = 0; enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_idle(30, "drop");
        check("drop_one_read", n_rd, 1);
        check("drop_left", exp_q.size(), 3);
        check("drop_busy", int'(busy), 0);
        check("drop_rd_count", int'(rd_count), 1);
        enable = 1'b1;
        wait_idle(40, "resume");
        check("resume_no_loss", exp_q.size(), 0);
        check("resume_rd_count", int'(rd_count), 4);

        // Asynchronous reset in the middle of a stalled burst
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h51 + i));
        repeat (4) tick();
        check("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_reset_rd_en", int'(rd_en), 0);
        check("mid_reset_m_valid", int'(m_valid), 0);
        check("mid_reset_m_data", int'(m_data), 0);
        check("mid_reset_rd_count", int'(rd_count), 0);
        check("mid_reset_uflow", int'(underflow_seen), 0);
        check("mid_reset_busy", int'(busy), 0);
        fq.delete();
        exp_q.delete();
        empty = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Randomized traffic: 17 words wrap the 4-bit counter and the pointers
        pushed = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (pushed < 17 && $urandom_range(0, 1) == 1) begin
                push_word(DW'($urandom));
                pushed++;
            end
            enable  = ($urandom_range(0, 4) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
            done = (pushed == 17) && (fq.size() == 0) && !busy && (exp_q.size() == 0);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wrap_timeout: pushed=%0d left=%0d expected drained", pushed, exp_q.size());
        end
        check("wrap_rd_count", int'(rd_count), 1);
        check("wrap_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
